peri_cmd_bridge: RTL and testbench
==================================

// Module: peri_cmd_bridge
// PURPOSE
//  Upstream neighbour of the PIM peripheral top. Accepts RISC-V MMIO requests on a valid/ready port and buffers them in an in-order FIFO.
//  Replays each request onto the peripheral's per-cycle address/data strobe interface as a one-cycle pulse, separated by programmable idle gaps.
//  For reads, captures the peripheral's data output after a fixed latency and returns it on a response port.
// PARAMETERS
//  FIFO_DEPTH  4           command FIFO entries; power of 2, >=2
//  MIN_GAP     1           idle cycles forced between consecutive issued commands; 0..15
//  READ_LAT    1           cycles from read issue to peri_data_i sample; 1..7
//  IDLE_ADDR   32'h0       address driven when no command is issued (decodes as NOP)
// PORTS
//  clk_i          in   1   clock, all logic rising-edge
//  rst_i          in   1   asynchronous reset, active-high
//  req_valid_i    in   1   core request valid
//  req_ready_o    out  1   bridge can accept request (FIFO not full)
//  req_we_i       in   1   1=write, 0=read
//  req_addr_i     in   32  request address
//  req_wdata_i    in   32  write data (ignored for reads)
//  rsp_valid_o    out  1   one-cycle pulse: read data valid
//  rsp_rdata_o    out  32  read data, held until next rsp_valid_o
//  peri_address_o out  32  address strobe to peripheral
//  peri_data_o    out  32  data strobe to peripheral
//  peri_data_i    in   32  peripheral read-data return
//  busy_o         out  1   FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset: FIFO empty; FSM=IDLE; peri_address_o=IDLE_ADDR; peri_data_o=0; rsp_valid_o=0; rsp_rdata_o=0; busy_o=0; req_ready_o=1.
//  Accept: handshake when req_valid_i&&req_ready_o; entry {we,addr,wdata} pushed. req_ready_o = (count!=FIFO_DEPTH), combinational from count only.
//  Push and pop in the same cycle are legal; count is unchanged. Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//  FSM states:
//   IDLE: if FIFO non-empty -> pop, register peri_* <= entry, -> ISSUE.
//   ISSUE: strobe is visible for exactly 1 cycle. Next state: read -> RD_WAIT (load lat_cnt=READ_LAT-1); else MIN_GAP>0 -> GAP (gap_cnt=MIN_GAP-1); else IDLE.
//    For a write with MIN_GAP=0 and the FIFO non-empty, the next entry pops directly; back-to-back strobes are allowed.
//   RD_WAIT: peri_address_o=IDLE_ADDR. When lat_cnt==0: rsp_rdata_o<=peri_data_i, rsp_valid_o=1 next cycle. Then -> GAP, or -> IDLE if MIN_GAP==0.
//   GAP: peri_address_o=IDLE_ADDR, peri_data_o=0; decrement gap_cnt; at 0 -> IDLE.
//  Outside ISSUE, peri_address_o=IDLE_ADDR and peri_data_o=0. Outputs are registered; the first strobe appears 2 cycles after the accepting edge when idle.
//  Ordering: strict FIFO order. Only one read is outstanding; no issue occurs during RD_WAIT/GAP.
//  Reads carry addr only; peri_data_o=0 during a read strobe.
//  Timing: read latency from acceptance (empty FIFO) to rsp_valid_o = 2+READ_LAT+1 cycles.
//  A request whose addr equals IDLE_ADDR is still issued (one cycle of IDLE_ADDR); no special-casing.
//  Reset mid-operation: FIFO flushed; in-flight read dropped with no rsp_valid_o; outputs return to reset values asynchronously.
//  Full FIFO: req_ready_o=0; held request waits; no entry is overwritten or lost.
// CONFIGURATION
//  PERI_CMD_STATS_EN defined:
//   Adds outputs stat_wr_o[15:0] and stat_rd_o[15:0], counting issued writes/reads (incremented in ISSUE). Saturate at 16'hFFFF; reset 0.
//   Adds input stat_clr_i (synchronous clear, wins over increment).
//  PERI_CMD_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Single write A=0x10 D=0xCAFE, MIN_GAP=1 -> peri_address_o=0x10, peri_data_o=0xCAFE for exactly 1 cycle, 2 cycles after accept; then IDLE_ADDR/0.
//  2 Five back-to-back writes, FIFO_DEPTH=4, continuous valid -> req_ready_o drops when count=4; all 5 strobes issued in order with 1-cycle gaps; none lost.
//  3 Read A=0x20, READ_LAT=2, peri_data_i=0x1234_5678 -> rsp_valid_o pulses once with rsp_rdata_o=0x12345678 at cycle 5 after accept.
//  4 Write,read,write queued together -> second write strobe appears only after rsp_valid_o plus MIN_GAP idle cycles.
//  5 Assert rst_i during RD_WAIT with 2 entries queued -> no rsp_valid_o; peri_address_o=IDLE_ADDR immediately; busy_o=0; req_ready_o=1.
//  6 (PERI_CMD_STATS_EN) 3 writes + 2 reads -> stat_wr_o=3, stat_rd_o=2; pulsing stat_clr_i -> both 0 next cycle.

Source files
------------

// File: rtl/peri_cmd_bridge_if.sv
// Core-side MMIO request/response bundle used by peri_cmd_bridge.
interface peri_cmd_bridge_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/peri_cmd_bridge.sv
// Buffers MMIO requests and replays them as one-cycle peripheral strobes; returns read data.
// Optional issued-command counters are built when PERI_CMD_STATS_EN is defined.
module peri_cmd_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MIN_GAP    = 1,
  parameter int unsigned READ_LAT   = 1,
  parameter logic [31:0] IDLE_ADDR  = 32'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  peri_cmd_bridge_if.slave core_if,
  output logic [31:0]      peri_address_o,
  output logic [31:0]      peri_data_o,
  input  logic [31:0]      peri_data_i,
`ifdef PERI_CMD_STATS_EN
  input  logic             stat_clr_i,
  output logic [15:0]      stat_wr_o,
  output logic [15:0]      stat_rd_o,
`endif
  output logic             busy_o
);

  localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [2:0]    LAT_LOAD = 3'(READ_LAT - 1);
  localparam bit            HAS_GAP  = (MIN_GAP > 0);
  localparam logic [3:0]    GAP_LOAD = HAS_GAP ? 4'(MIN_GAP - 1) : 4'd0;

  logic [64:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop, fifo_ne;
  logic [64:0]   head;

  assign core_if.req_ready = (count_q != FULL_CNT);
  assign push    = core_if.req_valid && core_if.req_ready;
  assign fifo_ne = (count_q != '0);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {core_if.req_we, core_if.req_addr, core_if.req_wdata};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // IDLE: wait/pop | ISSUE: strobe visible | RD_WAIT: read latency | GAP: forced idle spacing
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_GAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic        rd_q, rd_d, rsp_q, rsp_d, take;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  gap_q, gap_d;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    addr_d  = IDLE_ADDR;
    data_d  = '0;
    rd_d    = rd_q;
    lat_d   = lat_q;
    gap_d   = gap_q;
    rsp_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (fifo_ne) take = 1'b1;
      end
      S_ISSUE: begin
        if (rd_q) begin
          state_d = S_RD_WAIT;
          lat_d   = LAT_LOAD;
        end else if (HAS_GAP) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (fifo_ne) begin
          take = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == '0) begin
          rsp_d   = 1'b1;
          rdata_d = peri_data_i;
          if (HAS_GAP) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_GAP: begin
        // the last gap cycle pops directly so spacing is exactly MIN_GAP idle cycles
        if (gap_q == '0) begin
          if (fifo_ne) take = 1'b1;
          else         state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      state_d = S_ISSUE;
      addr_d  = head[63:32];
      data_d  = head[64] ? head[31:0] : 32'h0;
      rd_d    = ~head[64];
    end
  end

  assign pop = take;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= IDLE_ADDR;
      data_q  <= '0;
      rd_q    <= 1'b0;
      lat_q   <= '0;
      gap_q   <= '0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      lat_q   <= lat_d;
      gap_q   <= gap_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign peri_address_o    = addr_q;
  assign peri_data_o       = data_q;
  assign core_if.rsp_valid = rsp_q;
  assign core_if.rsp_rdata = rdata_q;
  assign busy_o            = fifo_ne || (state_q != S_IDLE);

`ifdef PERI_CMD_STATS_EN
  logic [15:0] stat_wr_q, stat_rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else if (stat_clr_i) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else if (state_q == S_ISSUE) begin
      if (rd_q) begin
        if (stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 1'b1;
      end else begin
        if (stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 1'b1;
      end
    end
  end

  assign stat_wr_o = stat_wr_q;
  assign stat_rd_o = stat_rd_q;
`endif

endmodule

// File: tb/tb_peri_cmd_bridge.sv
// Bench for peri_cmd_bridge: directed scenarios plus random traffic against a timing-arithmetic model.
module tb_peri_cmd_bridge;
  localparam int          DEPTH = 4;
  localparam int          GAP   = 1;
  localparam int          LAT   = 2;
  localparam logic [31:0] IDLE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] peri_addr, peri_wdata, peri_rdata;
  logic        busy;
`ifdef PERI_CMD_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_wr, stat_rd;
`endif
  int cyc = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  peri_cmd_bridge_if bus();

  peri_cmd_bridge #(
    .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP), .READ_LAT(LAT), .IDLE_ADDR(IDLE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .core_if(bus),
    .peri_address_o(peri_addr),
    .peri_data_o(peri_wdata),
    .peri_data_i(peri_rdata),
`ifdef PERI_CMD_STATS_EN
    .stat_clr_i(stat_clr),
    .stat_wr_o(stat_wr),
    .stat_rd_o(stat_rd),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // peripheral read data is a known function of the cycle number
  function automatic logic [31:0] pfn(input int c);
    return 32'h1234_5678 ^ (32'(c) * 32'h0001_0101);
  endfunction
  assign peri_rdata = pfn(cyc);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct { int push; int issue; logic we; logic [31:0] addr; logic [31:0] data; } ent_t;
  typedef struct { int at; logic [31:0] data; } rsp_t;

  ent_t        mq[$];
  rsp_t        rq[$];
  int          last_issue = 0, busy_end = 0;
  logic        last_rd = 1'b0, have_last = 1'b0;
  logic [31:0] m_rdata = '0;
  int          m_wr = 0, m_rd = 0;
  logic        saw_full = 1'b0;
  int          rsp_cnt = 0, obs_strobe = 0, obs_rsp = 0;

  // Model: an entry issues at max(accept+2, previous issue + spacing); reads respond LAT+1 later.
  always @(negedge clk) begin : monitor
    ent_t        e;
    rsp_t        r;
    logic [31:0] ea, ed;
    logic        erv, issuing, iss_we;
    int          occ, base;
    if (rst) begin
      mq.delete();
      rq.delete();
      have_last = 1'b0;
      busy_end  = 0;
      m_rdata   = '0;
      m_wr      = 0;
      m_rd      = 0;
    end
    ea = IDLE; ed = '0; issuing = 1'b0; iss_we = 1'b0;
    if (mq.size() > 0 && mq[0].issue == cyc) begin
      issuing = 1'b1;
      iss_we  = mq[0].we;
      ea      = mq[0].addr;
      ed      = mq[0].we ? mq[0].data : 32'h0;
    end
    check("strobe_addr", peri_addr, ea);
    check("strobe_data", peri_wdata, ed);
    erv = 1'b0;
    if (rq.size() > 0 && rq[0].at == cyc) begin
      erv     = 1'b1;
      r       = rq.pop_front();
      m_rdata = r.data;
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(erv));
    check("rsp_rdata", bus.rsp_rdata, m_rdata);
    occ = 0;
    foreach (mq[i]) if (mq[i].push < cyc && mq[i].issue > cyc) occ++;
    check("req_ready", 32'(bus.req_ready), 32'(occ != DEPTH));
    check("busy", 32'(busy), 32'((occ > 0) || (cyc < busy_end)));
`ifdef PERI_CMD_STATS_EN
    check("stat_wr", 32'(stat_wr), 32'(16'(m_wr)));
    check("stat_rd", 32'(stat_rd), 32'(16'(m_rd)));
    if (stat_clr) begin
      m_wr = 0;
      m_rd = 0;
    end else if (issuing) begin
      if (iss_we) m_wr++;
      else        m_rd++;
    end
`endif
    if (peri_addr != IDLE || peri_wdata != 32'h0) obs_strobe = cyc;
    if (bus.rsp_valid) begin
      obs_rsp = cyc;
      rsp_cnt++;
    end
    if (!bus.req_ready) saw_full = 1'b1;
    if (issuing) begin
      e = mq.pop_front();
      if (!e.we) begin
        r.at   = e.issue + LAT + 1;
        r.data = pfn(e.issue + LAT);
        rq.push_back(r);
      end
    end
    if (!rst && bus.req_valid && bus.req_ready) begin
      e.push = cyc;
      e.we   = bus.req_we;
      e.addr = bus.req_addr;
      e.data = bus.req_wdata;
      base   = cyc + 2;
      if (have_last) base = imax(base, last_issue + (last_rd ? LAT + 1 + GAP : GAP + 1));
      e.issue    = base;
      last_issue = base;
      last_rd    = !e.we;
      have_last  = 1'b1;
      busy_end   = base + (e.we ? GAP + 1 : LAT + 1 + GAP);
      mq.push_back(e);
    end
  end

  // tasks start and end at 1 time unit after a rising edge
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d, output int acc);
    int w;
    w = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    acc = cyc;
    check("send_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int   w;
    logic done;
    w = 0;
    done = 1'b0;
    while (!done && w < 400) begin
      @(negedge clk);
      w++;
      done = !busy && mq.size() == 0 && rq.size() == 0;
    end
    repeat (3) @(negedge clk);
    check("idle_reached", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          acc, t, got;
    logic [31:0] rd;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", peri_addr, IDLE);
    check("rst_data", peri_wdata, 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    rst = 1'b0;
    step();

    // single write: strobe two cycles after the accepting cycle, for one cycle only
    send(1'b1, 32'h10, 32'hCAFE, acc);
    step();
    check("t1_cycle", 32'(cyc - acc), 32'd2);
    check("t1_addr", peri_addr, 32'h10);
    check("t1_data", peri_wdata, 32'hCAFE);
    step();
    check("t1_addr_after", peri_addr, IDLE);
    check("t1_data_after", peri_wdata, 32'h0);
    wait_idle();

    // back-to-back writes, then a burst long enough to fill the FIFO
    for (int i = 0; i < 5; i++) send(1'b1, 32'h100 + 32'(i), 32'hA000 + 32'(i), t);
    wait_idle();
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) send(1'b1, 32'h200 + 32'(i), 32'hB000 + 32'(i), t);
    wait_idle();
    check("t2_full_seen", 32'(saw_full), 32'd1);

    // single read: response LAT+3 cycles after accept
    send(1'b0, 32'h20, 32'h0, acc);
    got = -1;
    rd  = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = cyc;
        rd  = bus.rsp_rdata;
        break;
      end
    end
    check("t3_latency", 32'(got - acc), 32'(LAT + 3));
    check("t3_rdata", rd, pfn(acc + LAT + 2));
    wait_idle();

    // write, read, write: second write waits for the response plus the gap
    send(1'b1, 32'h31, 32'h1111, t);
    send(1'b0, 32'h32, 32'h0, t);
    send(1'b1, 32'h33, 32'h3333, t);
    wait_idle();
    check("t4_spacing", 32'(obs_strobe - obs_rsp), 32'(GAP));

    // reset while a read is waiting for data with two writes queued
    send(1'b0, 32'h30, 32'h0, acc);
    send(1'b1, 32'h40, 32'h4, t);
    send(1'b1, 32'h50, 32'h5, t);
    check("t5_busy_before", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    rsp_cnt = 0;
    #1;
    check("t5_addr", peri_addr, IDLE);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(bus.req_ready), 32'd1);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_rsp", 32'(rsp_cnt), 32'd0);
    step();

    // random traffic
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) step();
      send(1'($urandom_range(0, 1)), $urandom() | 32'h1, $urandom(), t);
    end
    wait_idle();

`ifdef PERI_CMD_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 32'h600 + 32'(i), 32'h6, t);
    for (int i = 0; i < 2; i++) send(1'b0, 32'h700 + 32'(i), 32'h0, t);
    wait_idle();
    check("t6_stat_wr", 32'(stat_wr), 32'd3);
    check("t6_stat_rd", 32'(stat_rd), 32'd2);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("t6_clr_wr", 32'(stat_wr), 32'd0);
    check("t6_clr_rd", 32'(stat_rd), 32'd0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
